// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_cu control unit: FSM states, opcodes and
// branch condition codes.
package cpu_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_EX_ALU,
      S_EX_LD,
      S_EX_ST,
      S_EX_BR,
      S_EX_JR,
      S_HALT,
      S_FAULT,
      S_PAUSE
   } state_t;

   localparam logic [3:0] OP_LD  = 4'hB;
   localparam logic [3:0] OP_ST  = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_JR  = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [3:0] BR_ALWAYS = 4'd0;
   localparam logic [3:0] BR_Z      = 4'd1;
   localparam logic [3:0] BR_NZ     = 4'd2;
   localparam logic [3:0] BR_C      = 4'd3;
   localparam logic [3:0] BR_NC     = 4'd4;
   localparam logic [3:0] BR_N      = 4'd5;
   localparam logic [3:0] BR_NN     = 4'd6;

endpackage

// File: rtl/cpu_cu_brcond.sv
// Branch condition evaluator: condition code plus C/N/Z flags -> taken.
module cpu_cu_brcond
   import cpu_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic       c_i,
   input  logic       n_i,
   input  logic       z_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         BR_ALWAYS: taken_o = 1'b1;
         BR_Z:      taken_o = z_i;
         BR_NZ:     taken_o = ~z_i;
         BR_C:      taken_o = c_i;
         BR_NC:     taken_o = ~c_i;
         BR_N:      taken_o = n_i;
         BR_NN:     taken_o = ~n_i;
         default:   taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_cu.sv
// Control unit FSM for the 16-bit RISC core. Optional single-step mode
// (step input, PAUSE state) is enabled by defining CPU_CU_SINGLE_STEP_EN.
module cpu_cu
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int OPW     = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef CPU_CU_SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic [15:0] ir,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   input  logic        mem_ready,
   output logic        w_en,
   output logic        s_sel,
   output logic        adr_sel,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        pc_sel,
   output logic        ir_ld,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halted,
   output logic        fault
);

   localparam int CW = $clog2(TIMEOUT);

`ifdef CPU_CU_SINGLE_STEP_EN
   localparam state_t EX_NEXT = S_PAUSE;
`else
   localparam state_t EX_NEXT = S_FETCH;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OPW-1:0]  op;
   logic            br_taken;
   logic            tmo;
   logic            unused_ir;

   assign op        = ir[15 -: OPW];
   assign tmo       = (cnt_q == CW'(TIMEOUT - 1));
   assign unused_ir = ^ir[7:0];

   cpu_cu_brcond u_brcond (
      .cond_i  (ir[11:8]),
      .c_i     (C),
      .n_i     (N),
      .z_i     (Z),
      .taken_o (br_taken)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter defaults to zero so any state change clears it; only an
   // unanswered memory wait keeps it counting.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      w_en    = 1'b0;
      s_sel   = 1'b0;
      adr_sel = 1'b0;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      pc_sel  = 1'b0;
      ir_ld   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_ld   = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end else if (tmo) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            if (op == OPW'(OP_LD))       state_d = S_EX_LD;
            else if (op == OPW'(OP_ST))  state_d = S_EX_ST;
            else if (op == OPW'(OP_BR))  state_d = S_EX_BR;
            else if (op == OPW'(OP_JR))  state_d = S_EX_JR;
            else if (op == OPW'(OP_HLT)) state_d = S_HALT;
            else                         state_d = S_EX_ALU;
         end
         S_EX_ALU: begin
            w_en    = 1'b1;
            state_d = EX_NEXT;
         end
         S_EX_LD: begin
            adr_sel = 1'b1;
            mem_rd  = 1'b1;
            if (mem_ready) begin
               w_en    = 1'b1;
               s_sel   = 1'b1;
               state_d = EX_NEXT;
            end else if (tmo) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_EX_ST: begin
            adr_sel = 1'b1;
            mem_wr  = 1'b1;
            if (mem_ready)  state_d = EX_NEXT;
            else if (tmo)   state_d = S_FAULT;
            else            cnt_d   = cnt_q + CW'(1);
         end
         S_EX_BR: begin
            pc_ld   = br_taken;
            state_d = EX_NEXT;
         end
         S_EX_JR: begin
            pc_ld   = 1'b1;
            pc_sel  = 1'b1;
            state_d = EX_NEXT;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
`ifdef CPU_CU_SINGLE_STEP_EN
         S_PAUSE: if (step) state_d = S_FETCH;
`endif
         default: state_d = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_cpu_cu.sv
// Scoreboard bench for cpu_cu: instruction-level reference model queues the
// expected strobes per cycle; a monitor compares them on the falling edge.
module tb_cpu_cu;

   localparam int TIMEOUT = 16;

   // Packed output vector bit positions
   localparam logic [10:0] WEN  = 11'h400;
   localparam logic [10:0] SSEL = 11'h200;
   localparam logic [10:0] ADR  = 11'h100;
   localparam logic [10:0] PCLD = 11'h080;
   localparam logic [10:0] PCIN = 11'h040;
   localparam logic [10:0] PCSL = 11'h020;
   localparam logic [10:0] IRLD = 11'h010;
   localparam logic [10:0] MRD  = 11'h008;
   localparam logic [10:0] MWR  = 11'h004;
   localparam logic [10:0] HLT  = 11'h002;
   localparam logic [10:0] FLT  = 11'h001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] ir = '0;
   logic        C = 1'b0, N = 1'b0, Z = 1'b0;
   logic        mem_ready = 1'b0;
   logic        w_en, s_sel, adr_sel, pc_ld, pc_inc, pc_sel, ir_ld;
   logic        mem_rd, mem_wr, halted, fault;

   int n_checks = 0;
   int n_pass   = 0;
   logic [10:0] expq[$];

   cpu_cu #(.TIMEOUT(TIMEOUT), .OPW(4)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef CPU_CU_SINGLE_STEP_EN
      .step      (1'b1),
`endif
      .ir        (ir),
      .C         (C),
      .N         (N),
      .Z         (Z),
      .mem_ready (mem_ready),
      .w_en      (w_en),
      .s_sel     (s_sel),
      .adr_sel   (adr_sel),
      .pc_ld     (pc_ld),
      .pc_inc    (pc_inc),
      .pc_sel    (pc_sel),
      .ir_ld     (ir_ld),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   // Monitor: one expected vector per driven cycle
   always @(negedge clk) begin
      logic [10:0] act, e;
      if (expq.size() > 0) begin
         e   = expq.pop_front();
         act = {w_en, s_sel, adr_sel, pc_ld, pc_inc, pc_sel, ir_ld,
                mem_rd, mem_wr, halted, fault};
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL strobes t=%0t ir=%h rdy=%b: got %b want %b",
                       $time, ir, mem_ready, act, e);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic bit br_taken(input logic [3:0] cond, input logic [2:0] cnz);
      bit [15:0] tbl;
      tbl = {9'b0, ~cnz[1], cnz[1], ~cnz[2], cnz[2], ~cnz[0], cnz[0], 1'b1};
      return tbl[cond];
   endfunction

   task automatic drive(input logic [15:0] i_ir, input logic i_rdy,
                        input logic i_rst, input logic [2:0] cnz,
                        input logic [10:0] e);
      @(posedge clk); #1;
      ir = i_ir; mem_ready = i_rdy; reset = i_rst; {C, N, Z} = cnz;
      expq.push_back(e);
   endtask

   task automatic reset_from(input logic [10:0] cur);
      drive(16'($urandom), 1'($urandom), 1'b1, 3'($urandom), cur);
      drive(16'($urandom), 1'($urandom), 1'b0, 3'($urandom), '0);
   endtask

   task automatic fault_tail(input int hold);
      repeat (hold) drive(16'($urandom), 1'($urandom), 1'b0, 3'($urandom), FLT);
      reset_from(FLT);
   endtask

   // A memory phase: `waits` unanswered cycles, then ready (or fault)
   task automatic mem_phase(input logic [15:0] i_ir, input logic [10:0] e_wait,
                            input logic [10:0] e_done, input int waits,
                            output bit faulted);
      faulted = 0;
      for (int i = 0; i < waits && i < TIMEOUT; i++)
         drive(i_ir, 1'b0, 1'b0, 3'($urandom), e_wait);
      if (waits >= TIMEOUT) begin
         faulted = 1;
         fault_tail(3);
      end else begin
         drive(i_ir, 1'b1, 1'b0, 3'($urandom), e_done);
      end
   endtask

   task automatic run_instr(input logic [15:0] i_ir, input int fw, input int ew,
                            input logic [2:0] cnz, input int hold);
      bit f;
      mem_phase(16'($urandom), MRD, MRD | IRLD | PCIN, fw, f);
      if (f) return;
      drive(i_ir, 1'($urandom), 1'b0, 3'($urandom), '0);
      case (i_ir[15:12])
         4'hB: mem_phase(i_ir, ADR | MRD, ADR | MRD | WEN | SSEL, ew, f);
         4'hC: mem_phase(i_ir, ADR | MWR, ADR | MWR, ew, f);
         4'hD: drive(i_ir, 1'($urandom), 1'b0, cnz,
                     br_taken(i_ir[11:8], cnz) ? PCLD : 11'h0);
         4'hE: drive(i_ir, 1'($urandom), 1'b0, 3'($urandom), PCLD | PCSL);
         4'hF: begin
            repeat (hold) drive(i_ir, 1'($urandom), 1'b0, 3'($urandom), HLT);
            reset_from(HLT);
         end
         default: drive(i_ir, 1'($urandom), 1'b0, 3'($urandom), WEN);
      endcase
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) return 0;
      if (r < 18) return r - 11;
      if (r == 18) return TIMEOUT - 1;
      return TIMEOUT;
   endfunction

   initial begin
      bit f;
      @(posedge clk);
      drive(16'h0, 1'b0, 1'b1, 3'b0, '0);
      drive(16'h0, 1'b1, 1'b0, 3'b0, '0);

      run_instr(16'h1234, 0, 0, 3'b000, 0);
      run_instr(16'hB000, 0, 3, 3'b000, 0);
      run_instr(16'hD1F0, 0, 0, 3'b001, 0);
      run_instr(16'hD1F0, 0, 0, 3'b000, 0);
      run_instr(16'hD7A5, 0, 0, 3'b111, 0);
      run_instr(16'hD2F0, 1, 0, 3'b000, 0);
      run_instr(16'hE000, 2, 0, 3'b000, 0);
      run_instr(16'hC123, 0, TIMEOUT - 1, 3'b000, 0);
      run_instr(16'hA000, TIMEOUT - 1, 0, 3'b000, 0);
      run_instr(16'h5555, TIMEOUT, 0, 3'b000, 0);
      run_instr(16'hB111, 0, TIMEOUT, 3'b000, 0);
      run_instr(16'hF000, 0, 0, 3'b000, 20);

      // Reset in the middle of a store, with mem_wr active
      mem_phase(16'h0, MRD, MRD | IRLD | PCIN, 0, f);
      drive(16'hC000, 1'b0, 1'b0, 3'b0, '0);
      drive(16'hC000, 1'b0, 1'b1, 3'b0, ADR | MWR);
      drive(16'hC000, 1'b1, 1'b0, 3'b0, '0);

      for (int k = 0; k < 300; k++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         run_instr(ins, pick_wait(), pick_wait(), 3'($urandom),
                   $urandom_range(1, 5));
      end

      @(negedge clk); @(negedge clk);
      if (expq.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected vectors left, want 0", expq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
